seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Front-end controller for the serial sequence detector: accepts parallel words over valid/ready,
//  serialises them MSB-first one bit per clk, runs a programmable Mealy-style pattern match
//  (default 1100), and counts matches. Pattern, length and overlap mode are runtime-configurable.
// PARAMETERS
//  DATA_W  8  input word width; also the number of SHIFT cycles per word
//  PAT_W   4  maximum pattern length in bits
//  CNT_W   8  width of the match counter
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  cfg_we       in   1       config write strobe
//  cfg_pattern  in   PAT_W   pattern; bit len-1 = first-arriving bit, bit 0 = newest
//  cfg_len      in   3       pattern length; 0 = detection off; >PAT_W clamps to PAT_W
//  cfg_overlap  in   1       1 = overlapping matches allowed
//  in_valid     in   1       input word valid
//  in_data      in   DATA_W  input word
//  in_ready     out  1       controller can take a word
//  busy         out  1       SHIFT in progress
//  match        out  1       1-cycle match pulse
//  match_count  out  CNT_W   matches since reset/config
//  count_sat    out  1       sticky: match_count saturated
// BEHAVIOUR
//  Reset (sync): state=IDLE; hist=0, hcnt=0; match=0, match_count=0, count_sat=0; in_ready=1.
//    Config resets to pattern=4'b1100, len=4, overlap=1.
//  FSM IDLE: in_ready=1 except in cycles where cfg_we=1.
//    A word is accepted on in_valid&in_ready: latch in_data, bit index=DATA_W-1, go to SHIFT.
//  FSM SHIFT: in_ready=0, busy=1. Consume one bit per cycle, MSB first.
//    After the LSB is consumed, return to IDLE.
//    Throughput: one word per DATA_W+1 cycles; no back-to-back acceptance.
//  Detection on each consumed bit b:
//    window = {hist,b}; hist <= window[PAT_W-1:0]; hcnt = min(hcnt+1, PAT_W).
//    Match when len!=0 && hcnt_new>=len && window[len-1:0]==cfg_pattern[len-1:0].
//  On match:
//    - match=1 in the cycle after the matching bit is consumed (registered).
//    - match_count += 1, saturating at all-ones; on reaching all-ones, count_sat=1 (sticky).
//    - If overlap=0, hcnt <= 0, so bits from the matched pattern cannot be reused.
//  Stream continuity: hist/hcnt persist across words and idle gaps; only cfg_we or reset clears them.
//  Config writes:
//    - cfg_we is honoured only in IDLE. It loads pattern/len/overlap and clears hist, hcnt,
//      match_count and count_sat.
//    - cfg_we has priority over in_valid that cycle (in_ready=0, no word taken).
//    - cfg_we while busy is ignored entirely (no state change).
//  in_data is sampled only at handshake; changes during SHIFT have no effect.
//  Reset mid-SHIFT aborts the word (bits lost); all state returns to reset values next cycle.
//  A pending match pulse is also dropped.
// TESTING
//  1 Default config, word 8'b1100_1100 -> match pulses after SHIFT bits 3 and 7; match_count=2;
//    in_ready re-asserts 9 cycles after accept.
//  2 cfg 101/len3/overlap1, word 8'b1010_1010 -> 3 matches (bits 2,4,6);
//    same with overlap0 -> 2 matches (bits 2,6).
//  3 Default config, words 8'b0000_0011 then 8'b0000_0000 with idle gap -> exactly 1 match,
//    at bit 1 of the second word.
//  4 cfg_we pulsed during SHIFT -> ignored, count and pattern unchanged;
//    cfg_we with in_valid in IDLE -> config taken, word held off one cycle.
//  5 CNT_W=2, pattern 1/len1, word 8'hFF -> count 1,2,3 then stays 3; count_sat=1 from 3rd match.
//  6 reset asserted at SHIFT bit 4 of 8'b1100_1100 -> no match pulse; count=0;
//    in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Bus bundle for the serial sequence detector front end: configuration port,
// valid/ready word input and the match/status outputs.
interface seq_detect_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
);
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic [2:0]        cfg_len;
    logic              cfg_overlap;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              match;
    logic [CNT_W-1:0]  match_count;
    logic              count_sat;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_data,
        input  in_ready, busy, match, match_count, count_sat
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_data,
        output in_ready, busy, match, match_count, count_sat
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit serialiser feeding a programmable Mealy pattern matcher with a
// saturating match counter; the bit history survives across words.
module seq_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    seq_detect_ctrl_if.slave bus
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int HC_W  = $clog2(PAT_W + 1);
    localparam logic [2:0]       MAX_LEN = 3'(PAT_W);
    localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1100);
    localparam logic [2:0]       DEF_LEN = (PAT_W < 4) ? 3'(PAT_W) : 3'd4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_bitIdx;
    logic [PAT_W-1:0]  r_pattern;
    logic [2:0]        r_len;
    logic              r_overlap;
    logic [PAT_W-1:0]  r_hist;
    logic [HC_W-1:0]   r_hcnt;
    logic              r_match;
    logic [CNT_W-1:0]  r_count;
    logic              r_sat;

    logic              w_inReady;
    logic              w_busy;
    logic              w_accept;
    logic              w_cfgTake;
    logic              w_bitValid;
    logic              w_bit;
    logic [PAT_W:0]    w_window;
    logic [HC_W-1:0]   w_hcntNext;
    logic [PAT_W-1:0]  w_mask;
    logic              w_hit;
    logic [2:0]        w_lenClamped;
    logic [CNT_W-1:0]  w_countInc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Config writes win over a waiting word, so the word is held off in that cycle.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_cfgTake   = 1'b0;
        w_bitValid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = !bus.cfg_we;
                w_cfgTake = bus.cfg_we;
                w_accept  = bus.in_valid && !bus.cfg_we;
                if (w_accept) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                w_busy     = 1'b1;
                w_bitValid = 1'b1;
                if (r_bitIdx == '0) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_bit        = r_data[r_bitIdx];
    assign w_window     = {r_hist, w_bit};
    assign w_hcntNext   = (r_hcnt == HC_W'(PAT_W)) ? r_hcnt : r_hcnt + HC_W'(1);
    assign w_mask       = ~({PAT_W{1'b1}} << r_len);
    assign w_lenClamped = (bus.cfg_len > MAX_LEN) ? MAX_LEN : bus.cfg_len;
    assign w_countInc   = r_count + CNT_W'(1);

    // Only bits received since the last clear may contribute to a match.
    assign w_hit = w_bitValid && (r_len != 3'd0) &&
                   (int'(w_hcntNext) >= int'(r_len)) &&
                   ((w_window[PAT_W-1:0] & w_mask) == (r_pattern & w_mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= '0;
            r_bitIdx <= '0;
        end else if (w_accept) begin
            r_data   <= bus.in_data;
            r_bitIdx <= IDX_W'(DATA_W - 1);
        end else if (w_bitValid && (r_bitIdx != '0)) begin
            r_bitIdx <= r_bitIdx - IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= DEF_PAT;
            r_len     <= DEF_LEN;
            r_overlap <= 1'b1;
        end else if (w_cfgTake) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= w_lenClamped;
            r_overlap <= bus.cfg_overlap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist  <= '0;
            r_hcnt  <= '0;
            r_match <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (w_cfgTake) begin
                r_hist  <= '0;
                r_hcnt  <= '0;
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_bitValid) begin
                r_hist <= w_window[PAT_W-1:0];
                r_hcnt <= (w_hit && !r_overlap) ? '0 : w_hcntNext;
                if (w_hit && !(&r_count)) begin
                    r_count <= w_countInc;
                    if (&w_countInc) begin
                        r_sat <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.in_ready    = w_inReady;
    assign bus.busy        = w_busy;
    assign bus.match       = r_match;
    assign bus.match_count = r_count;
    assign bus.count_sat   = r_sat;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench: a bit-queue reference model predicts every match pulse
// (cycle, count, sticky flag) and a negedge monitor pops and compares them.
module tb_seq_detect_ctrl;

    localparam int DATA_W  = 8;
    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int unsigned due;
        int          cnt;
        bit          sat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seq_detect_ctrl_if #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    exp_t expQ[$];
    exp_t monE;
    bit   stream[$];
    int   mPat;
    int   mLen;
    bit   mOvl;
    int   mCount;
    bit   mSat;
    int   nChecks = 0;
    int   nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void modelReset();
        mPat   = 4'b1100;
        mLen   = 4;
        mOvl   = 1'b1;
        mCount = 0;
        mSat   = 1'b0;
        stream.delete();
    endfunction

    function automatic void modelConfig(input int pat, input int len, input bit ovl);
        mPat   = pat;
        mLen   = (len > PAT_W) ? PAT_W : len;
        mOvl   = ovl;
        mCount = 0;
        mSat   = 1'b0;
        stream.delete();
    endfunction

    // Bit j (1 = MSB) is consumed j cycles after acceptance; its pulse shows one cycle later.
    function automatic void modelWord(input logic [DATA_W-1:0] w, input int unsigned acc);
        bit b;
        bit hit;
        for (int j = 1; j <= DATA_W; j++) begin
            b = w[DATA_W-j];
            stream.push_back(b);
            if (stream.size() > PAT_W) void'(stream.pop_front());
            hit = 1'b0;
            if (mLen != 0 && stream.size() >= mLen) begin
                hit = 1'b1;
                for (int k = 0; k < mLen; k++) begin
                    if (stream[stream.size()-1-k] != mPat[k]) hit = 1'b0;
                end
            end
            if (hit) begin
                if (mCount < CNT_MAX) mCount++;
                if (mCount == CNT_MAX) mSat = 1'b1;
                expQ.push_back('{acc + j + 1, mCount, mSat});
                if (!mOvl) stream.delete();
            end
        end
    endfunction

    always @(negedge clk) begin
        if (expQ.size() > 0 && expQ[0].due <= cyc) begin
            monE = expQ.pop_front();
            checkOutput("match_pulse", bus.match, 1);
            checkOutput("match_count", bus.match_count, monE.cnt);
            checkOutput("count_sat", bus.count_sat, monE.sat);
        end else if (bus.match !== 1'b0) begin
            checkOutput("spurious_match", bus.match, 0);
        end
    end

    // All driving tasks enter and leave 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] w, input bit waitDone, output int unsigned acc);
        bit accepted;
        int unsigned lat;
        accepted     = 1'b0;
        acc          = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int n = 0; n < 40 && !accepted; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                accepted = 1'b1;
                acc      = cyc;
                modelWord(w, cyc);
            end
        end
        checkOutput("word_accepted", accepted, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
        if (waitDone && accepted) begin
            lat = 0;
            for (int n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (n == 1) checkOutput("busy_in_shift", bus.busy, 1);
                if (bus.in_ready === 1'b1) begin
                    lat = cyc - acc;
                    break;
                end
            end
            checkOutput("ready_latency", lat, DATA_W + 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfgWrite(input int pat, input int len, input bit ovl, input bit expectTaken,
                            output int unsigned cfgCyc);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat[PAT_W-1:0];
        bus.cfg_len     = len[2:0];
        bus.cfg_overlap = ovl;
        @(negedge clk);
        checkOutput("cfg_blocks_ready", bus.in_ready, 0);
        cfgCyc = cyc;
        if (expectTaken) modelConfig(pat, len, ovl);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic waitReady();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
        end
        checkOutput("ready_after_busy", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int unsigned acc;
        int unsigned cfgCyc;
        int unsigned sel;
        bus.cfg_we      = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", bus.in_ready, 1);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_match", bus.match, 0);
        checkOutput("reset_count", bus.match_count, 0);
        checkOutput("reset_sat", bus.count_sat, 0);
        @(posedge clk);
        #1;

        $display("[TB] default pattern on 1100_1100");
        applyStimulus(8'b1100_1100, 1'b1, acc);
        checkOutput("t1_count", bus.match_count, 2);

        $display("[TB] pattern 101 with and without overlap");
        cfgWrite(4'b0101, 3, 1'b1, 1'b1, cfgCyc);
        applyStimulus(8'b1010_1010, 1'b1, acc);
        checkOutput("t2_overlap_count", bus.match_count, 3);
        cfgWrite(4'b0101, 3, 1'b0, 1'b1, cfgCyc);
        applyStimulus(8'b1010_1010, 1'b1, acc);
        checkOutput("t2_no_overlap_count", bus.match_count, 2);

        $display("[TB] history spans words and idle gaps");
        cfgWrite(4'b1100, 4, 1'b1, 1'b1, cfgCyc);
        applyStimulus(8'b0000_0011, 1'b1, acc);
        idle(5);
        applyStimulus(8'b0000_0000, 1'b1, acc);
        checkOutput("t3_count", bus.match_count, 1);

        $display("[TB] config write while busy is ignored");
        applyStimulus(8'b1100_1100, 1'b0, acc);
        idle(1);
        cfgWrite(4'b0011, 2, 1'b0, 1'b0, cfgCyc);
        waitReady();
        checkOutput("t4_busy_cfg_count", bus.match_count, 3);
        applyStimulus(8'b1100_1100, 1'b1, acc);
        checkOutput("t4_pattern_kept", bus.match_count, 5);

        $display("[TB] config write has priority over a waiting word");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'b1010_1010;
        cfgWrite(4'b0101, 3, 1'b1, 1'b1, cfgCyc);
        applyStimulus(8'b1010_1010, 1'b1, acc);
        checkOutput("t4_accept_delayed", acc, cfgCyc + 1);
        checkOutput("t4_new_cfg_count", bus.match_count, 3);

        $display("[TB] counter saturation");
        cfgWrite(4'b0001, 1, 1'b1, 1'b1, cfgCyc);
        repeat (31) applyStimulus(8'hFF, 1'b1, acc);
        checkOutput("t5_count_248", bus.match_count, 248);
        checkOutput("t5_not_sat", bus.count_sat, 0);
        repeat (2) applyStimulus(8'hFF, 1'b1, acc);
        checkOutput("t5_count_max", bus.match_count, CNT_MAX);
        checkOutput("t5_sat", bus.count_sat, 1);

        $display("[TB] reset in the middle of a word");
        cfgWrite(4'b1100, 4, 1'b1, 1'b1, cfgCyc);
        applyStimulus(8'b1100_1100, 1'b0, acc);
        idle(3);
        reset = 1'b1;
        while (expQ.size() > 0 && expQ[expQ.size()-1].due > cyc) void'(expQ.pop_back());
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_in_ready", bus.in_ready, 1);
        checkOutput("t6_busy", bus.busy, 0);
        checkOutput("t6_match", bus.match, 0);
        checkOutput("t6_count", bus.match_count, 0);
        @(posedge clk);
        #1;
        applyStimulus(8'b1100_1100, 1'b1, acc);
        checkOutput("t6_after_reset_count", bus.match_count, 2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                cfgWrite(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                         bit'($urandom_range(0, 1)), 1'b1, cfgCyc);
            end else begin
                applyStimulus(DATA_W'($urandom), 1'b1, acc);
                idle(int'($urandom_range(0, 3)));
            end
        end

        for (int n = 0; n < 20 && expQ.size() > 0; n++) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        checkOutput("final_count", bus.match_count, mCount);
        checkOutput("final_sat", bus.count_sat, mSat);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
